// File: rtl/eo_count_sequencer.sv
// ----------------------------------------------------------------------------
// eo_count_sequencer
//
// Drives an external even/odd counter through a configurable number of
// rounds. A run is CLEAR (one-cycle counter clear), then one or more rounds of
// EVEN_LEN cycles in even mode followed by ODD_LEN cycles in odd mode, then a
// one-cycle FINISH that pulses DONE.
//
// Ports
//   CLK        sole clock, rising edge
//   RST        asynchronous active-high reset
//   START      begin a run (sampled only while idle)
//   ABORT      cancel a running sequence at the next edge (ignored while idle)
//   EVEN_LEN   cycles per even phase (latched at start)
//   ODD_LEN    cycles per odd phase (latched at start)
//   ROUNDS     number of even+odd rounds (latched at start)
//   CNT_OE     counter mode: 0 = even, 1 = odd
//   CNT_CLR    one-cycle counter clear
//   BUSY       high in every state except idle
//   DONE       one-cycle pulse on normal completion
//   PHASE      0 idle/finish, 1 clear, 2 even, 3 odd
//   ROUND_CNT  index of the round in progress
// ----------------------------------------------------------------------------
module eo_count_sequencer #(
  parameter int LEN_W = 4,
  parameter int RND_W = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  input  logic [LEN_W-1:0] EVEN_LEN,
  input  logic [LEN_W-1:0] ODD_LEN,
  input  logic [RND_W-1:0] ROUNDS,
  output logic             CNT_OE,
  output logic             CNT_CLR,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       PHASE,
  output logic [RND_W-1:0] ROUND_CNT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_EVEN,
    S_ODD,
    S_FINISH
  } state_t;

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] even_len_reg, even_len_next;
  logic [LEN_W-1:0] odd_len_reg, odd_len_next;
  logic [RND_W-1:0] rounds_reg, rounds_next;
  logic [RND_W-1:0] round_cnt_reg, round_cnt_next;
  // Counts 1..len inside a phase; compared before incrementing so it never
  // has to hold more than the phase length itself.
  logic [LEN_W-1:0] phase_cnt_reg, phase_cnt_next;
  logic             round_end;

  logic             cnt_oe_reg, cnt_clr_reg, busy_reg, done_reg;
  logic [1:0]       phase_reg;

  always_comb begin
    state_next     = state_reg;
    even_len_next  = even_len_reg;
    odd_len_next   = odd_len_reg;
    rounds_next    = rounds_reg;
    round_cnt_next = round_cnt_reg;
    phase_cnt_next = phase_cnt_reg;
    round_end      = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (START) begin
          even_len_next  = EVEN_LEN;
          odd_len_next   = ODD_LEN;
          rounds_next    = ROUNDS;
          round_cnt_next = '0;
          state_next     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        phase_cnt_next = LEN_W'(1);
        if (rounds_reg == '0 || (even_len_reg == '0 && odd_len_reg == '0))
          state_next = S_FINISH;
        else if (even_len_reg != '0)
          state_next = S_EVEN;
        else
          state_next = S_ODD;
      end
      S_EVEN: begin
        if (phase_cnt_reg == even_len_reg) begin
          if (odd_len_reg != '0) begin
            state_next     = S_ODD;
            phase_cnt_next = LEN_W'(1);
          end else begin
            round_end = 1'b1;
          end
        end else begin
          phase_cnt_next = phase_cnt_reg + LEN_W'(1);
        end
      end
      S_ODD: begin
        if (phase_cnt_reg == odd_len_reg)
          round_end = 1'b1;
        else
          phase_cnt_next = phase_cnt_reg + LEN_W'(1);
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Rounds chain directly into each other: no clear and no idle gap.
    if (round_end) begin
      if (round_cnt_reg == rounds_reg - RND_W'(1)) begin
        state_next = S_FINISH;
      end else begin
        round_cnt_next = round_cnt_reg + RND_W'(1);
        phase_cnt_next = LEN_W'(1);
        state_next     = (even_len_reg != '0) ? S_EVEN : S_ODD;
      end
    end

    // Abort overrides every other transition of a running sequence.
    if (ABORT && state_reg != S_IDLE)
      state_next = S_IDLE;

    if (state_next == S_IDLE)
      round_cnt_next = '0;
  end

  // Outputs are decoded from the next state and registered with it, so each
  // output flop always agrees with the state flop it describes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      even_len_reg  <= '0;
      odd_len_reg   <= '0;
      rounds_reg    <= '0;
      round_cnt_reg <= '0;
      phase_cnt_reg <= '0;
      cnt_oe_reg    <= 1'b0;
      cnt_clr_reg   <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      phase_reg     <= 2'd0;
    end else begin
      state_reg     <= state_next;
      even_len_reg  <= even_len_next;
      odd_len_reg   <= odd_len_next;
      rounds_reg    <= rounds_next;
      round_cnt_reg <= round_cnt_next;
      phase_cnt_reg <= phase_cnt_next;
      cnt_oe_reg    <= (state_next == S_ODD);
      cnt_clr_reg   <= (state_next == S_CLEAR);
      busy_reg      <= (state_next != S_IDLE);
      done_reg      <= (state_next == S_FINISH);
      case (state_next)
        S_CLEAR: phase_reg <= 2'd1;
        S_EVEN:  phase_reg <= 2'd2;
        S_ODD:   phase_reg <= 2'd3;
        default: phase_reg <= 2'd0;
      endcase
    end
  end

  assign CNT_OE    = cnt_oe_reg;
  assign CNT_CLR   = cnt_clr_reg;
  assign BUSY      = busy_reg;
  assign DONE      = done_reg;
  assign PHASE     = phase_reg;
  assign ROUND_CNT = round_cnt_reg;

endmodule

// File: tb/tb_eo_count_sequencer.sv
// ----------------------------------------------------------------------------
// tb_eo_count_sequencer
//
// Directed bench for eo_count_sequencer. Inputs are driven and outputs are
// sampled on the falling edge; each scenario task checks its own results.
// ----------------------------------------------------------------------------
module tb_eo_count_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [3:0] EVEN_LEN = '0;
  logic [3:0] ODD_LEN = '0;
  logic [2:0] ROUNDS = '0;
  logic       CNT_OE, CNT_CLR, BUSY, DONE;
  logic [1:0] PHASE;
  logic [2:0] ROUND_CNT;

  int errors = 0;
  int checks = 0;

  logic       oe_log  [64];
  logic       clr_log [64];
  logic       done_log[64];
  logic [1:0] ph_log  [64];
  logic [2:0] rc_log  [64];
  int         n_busy;

  eo_count_sequencer #(.LEN_W(4), .RND_W(3)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT),
    .EVEN_LEN(EVEN_LEN), .ODD_LEN(ODD_LEN), .ROUNDS(ROUNDS),
    .CNT_OE(CNT_OE), .CNT_CLR(CNT_CLR), .BUSY(BUSY), .DONE(DONE),
    .PHASE(PHASE), .ROUND_CNT(ROUND_CNT)
  );

  always #5 CLK = ~CLK;

  // Pulse START for one edge; returns at the falling edge of the first busy
  // cycle (CLEAR).
  task automatic start_seq(input logic [3:0] e, input logic [3:0] o, input logic [2:0] r);
    @(negedge CLK);
    EVEN_LEN = e;
    ODD_LEN  = o;
    ROUNDS   = r;
    START    = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Records outputs for every busy cycle, bounded by budget.
  task automatic capture(input int budget);
    n_busy = 0;
    while (BUSY === 1'b1 && n_busy < budget) begin
      oe_log[n_busy]   = CNT_OE;
      clr_log[n_busy]  = CNT_CLR;
      done_log[n_busy] = DONE;
      ph_log[n_busy]   = PHASE;
      rc_log[n_busy]   = ROUND_CNT;
      n_busy++;
      @(negedge CLK);
    end
  endtask

  task automatic test_reset;
    logic [8:0] obs;
    #1;
    obs = {CNT_OE, CNT_CLR, BUSY, DONE, PHASE, ROUND_CNT};
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, 9'd0);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", BUSY);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic;
    logic [11:0] oe_v, clr_v, done_v, rc_v;
    start_seq(4'd2, 4'd3, 3'd2);
    // Changing the inputs mid-run must not disturb the latched configuration.
    EVEN_LEN = 4'd7;
    ODD_LEN  = 4'd1;
    ROUNDS   = 3'd5;
    capture(40);
    oe_v = '0; clr_v = '0; done_v = '0; rc_v = '0;
    for (int i = 0; i < 12; i++) begin
      oe_v[i]   = oe_log[i];
      clr_v[i]  = clr_log[i];
      done_v[i] = done_log[i];
      rc_v[i]   = rc_log[i][0];
    end
    checks++;
    if (n_busy !== 12) begin errors++; $display("FAIL basic_busy_len: got %0d expected 12", n_busy); end
    checks++;
    if (oe_v !== 12'b011100111000) begin errors++; $display("FAIL basic_oe: got %b expected %b", oe_v, 12'b011100111000); end
    checks++;
    if (clr_v !== 12'b000000000001) begin errors++; $display("FAIL basic_clr: got %b expected %b", clr_v, 12'b000000000001); end
    checks++;
    if (done_v !== 12'b100000000000) begin errors++; $display("FAIL basic_done: got %b expected %b", done_v, 12'b100000000000); end
    checks++;
    if (rc_v !== 12'b111111000000) begin errors++; $display("FAIL basic_round: got %b expected %b", rc_v, 12'b111111000000); end
    checks++;
    if ({ph_log[0], ph_log[1], ph_log[3], ph_log[11]} !== 8'b01_10_11_00) begin
      errors++;
      $display("FAIL basic_phase: got %b expected %b", {ph_log[0], ph_log[1], ph_log[3], ph_log[11]}, 8'b01101100);
    end
    checks++;
    if ({DONE, PHASE, ROUND_CNT} !== 6'd0) begin
      errors++;
      $display("FAIL basic_after: got %b expected %b", {DONE, PHASE, ROUND_CNT}, 6'd0);
    end
    $display("test_basic done: busy=%0d", n_busy);
  endtask

  task automatic test_even_zero;
    logic [5:0] oe_v, done_v;
    start_seq(4'd0, 4'd4, 3'd1);
    capture(40);
    oe_v = '0; done_v = '0;
    for (int i = 0; i < 6; i++) begin
      oe_v[i]   = oe_log[i];
      done_v[i] = done_log[i];
    end
    checks++;
    if (n_busy !== 6) begin errors++; $display("FAIL even0_busy_len: got %0d expected 6", n_busy); end
    checks++;
    if (oe_v !== 6'b011110) begin errors++; $display("FAIL even0_oe: got %b expected %b", oe_v, 6'b011110); end
    checks++;
    if (done_v !== 6'b100000) begin errors++; $display("FAIL even0_done: got %b expected %b", done_v, 6'b100000); end
    $display("test_even_zero done: busy=%0d", n_busy);
  endtask

  task automatic test_rounds_zero;
    logic [1:0] oe_v, clr_v, done_v;
    start_seq(4'd5, 4'd5, 3'd0);
    capture(40);
    oe_v = '0; clr_v = '0; done_v = '0;
    for (int i = 0; i < 2; i++) begin
      oe_v[i]   = oe_log[i];
      clr_v[i]  = clr_log[i];
      done_v[i] = done_log[i];
    end
    checks++;
    if (n_busy !== 2) begin errors++; $display("FAIL rnd0_busy_len: got %0d expected 2", n_busy); end
    checks++;
    if ({oe_v, clr_v, done_v} !== 6'b00_01_10) begin
      errors++;
      $display("FAIL rnd0_pattern: got %b expected %b", {oe_v, clr_v, done_v}, 6'b000110);
    end
    $display("test_rounds_zero done: busy=%0d", n_busy);
  endtask

  task automatic test_abort;
    int done_seen = 0;
    int busy_seen = 0;
    start_seq(4'd3, 4'd3, 3'd3);
    // Cycle 0 is CLEAR; round 1 ODD occupies cycles 10..12.
    for (int c = 1; c <= 11; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) done_seen++;
      if (c == 7) START = 1'b1;
      if (c == 8) START = 1'b0;
    end
    checks++;
    if ({PHASE, ROUND_CNT} !== {2'd3, 3'd1}) begin
      errors++;
      $display("FAIL abort_pre_state: got phase=%0d round=%0d expected phase=3 round=1", PHASE, ROUND_CNT);
    end
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    checks++;
    if ({BUSY, DONE, PHASE, CNT_OE} !== 5'd0) begin
      errors++;
      $display("FAIL abort_idle: got %b expected %b", {BUSY, DONE, PHASE, CNT_OE}, 5'd0);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) done_seen++;
      if (BUSY === 1'b1) busy_seen++;
    end
    checks++;
    if (done_seen !== 0 || busy_seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet: got done=%0d busy=%0d expected 0 0", done_seen, busy_seen);
    end
    // START together with ABORT while idle must still start a run.
    ABORT = 1'b1;
    START = 1'b1;
    EVEN_LEN = 4'd1; ODD_LEN = 4'd1; ROUNDS = 3'd1;
    @(negedge CLK);
    START = 1'b0;
    ABORT = 1'b0;
    checks++;
    if ({CNT_CLR, BUSY, PHASE} !== 4'b1101) begin
      errors++;
      $display("FAIL abort_start_idle: got %b expected %b", {CNT_CLR, BUSY, PHASE}, 4'b1101);
    end
    capture(40);
    $display("test_abort done");
  endtask

  task automatic test_back_to_back;
    logic [7:0] done_v, clr_v, busy_v;
    @(negedge CLK);
    EVEN_LEN = 4'd1; ODD_LEN = 4'd1; ROUNDS = 3'd1;
    START = 1'b1;
    done_v = '0; clr_v = '0; busy_v = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      done_v[i] = DONE;
      clr_v[i]  = CNT_CLR;
      busy_v[i] = BUSY;
    end
    START = 1'b0;
    // Run: CLEAR,EVEN,ODD,FINISH,IDLE,CLEAR,EVEN,ODD
    checks++;
    if (done_v !== 8'b00001000) begin errors++; $display("FAIL b2b_done: got %b expected %b", done_v, 8'b00001000); end
    checks++;
    if (clr_v !== 8'b00100001) begin errors++; $display("FAIL b2b_clr: got %b expected %b", clr_v, 8'b00100001); end
    checks++;
    if (busy_v !== 8'b11101111) begin errors++; $display("FAIL b2b_busy: got %b expected %b", busy_v, 8'b11101111); end
    capture(40);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_end: got busy=%b expected 0", BUSY); end
    $display("test_back_to_back done");
  endtask

  task automatic test_reset_mid;
    int done_seen = 0;
    int busy_seen = 0;
    start_seq(4'd5, 4'd5, 3'd2);
    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if ({BUSY, PHASE} !== 3'b110) begin
      errors++;
      $display("FAIL rstmid_pre: got %b expected %b", {BUSY, PHASE}, 3'b110);
    end
    #1 RST = 1'b1;
    #1;
    checks++;
    if ({CNT_OE, CNT_CLR, BUSY, DONE, PHASE, ROUND_CNT} !== 9'd0) begin
      errors++;
      $display("FAIL rstmid_async: got %b expected %b", {CNT_OE, CNT_CLR, BUSY, DONE, PHASE, ROUND_CNT}, 9'd0);
    end
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (DONE === 1'b1) done_seen++;
      if (BUSY === 1'b1) busy_seen++;
    end
    checks++;
    if (done_seen !== 0 || busy_seen !== 0) begin
      errors++;
      $display("FAIL rstmid_after: got done=%0d busy=%0d expected 0 0", done_seen, busy_seen);
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_even_zero();
    test_rounds_zero();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
